// File: rtl/definitions_pkg.sv
// Shared types for the board input stage: button bit positions and masks,
// the operand register layout and the test selector encoding.
package definitions_pkg;

    // Button bit positions inside the 5-bit button vectors
    localparam int BTNC_IDX = 4;
    localparam int BTNU_IDX = 3;
    localparam int BTND_IDX = 2;
    localparam int BTNL_IDX = 1;
    localparam int BTNR_IDX = 0;

    localparam logic [4:0] BTNC_MASK = 5'b10000;
    localparam logic [4:0] BTNU_MASK = 5'b01000;
    localparam logic [4:0] BTND_MASK = 5'b00100;
    localparam logic [4:0] BTNL_MASK = 5'b00010;
    localparam logic [4:0] BTNR_MASK = 5'b00001;

    typedef enum logic [2:0] {
        LEADING_ONES = 3'd0,
        NUM_ONES     = 3'd1,
        ADD          = 3'd2,
        SUB          = 3'd3,
        MULT         = 3'd4
    } test_selector_t;

    typedef struct packed {
        logic [7:0] hi_byte;
        logic [7:0] lo_byte;
    } ioreg_bytes_t;

    typedef union packed {
        logic [15:0]  word;
        ioreg_bytes_t bytes;
    } ioreg_union_t;

endpackage

// File: rtl/input_capture.sv
// Board input capture: synchronizes buttons and switches, debounces the
// buttons, and turns button presses into operand loads, test selection and
// a one-cycle execute request for the downstream stage.
module input_capture
    import definitions_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
    parameter int unsigned SYNC_STAGES     = 2
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [4:0]     btn_in,
    input  logic [15:0]    sw_in,
    output logic [4:0]     btn_db,
    output logic [4:0]     btn_pulse,
    output ioreg_union_t   ioreg,
    output test_selector_t test_sel,
    output logic           op_start
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 32'd2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 32'd1);

    // Buttons in the top 5 bits, switches in the low 16
    logic [20:0]      sync_q [SYNC_STAGES];
    logic [4:0]       btn_sync_s;
    logic [15:0]      sw_sync_s;

    logic [CNT_W-1:0] cnt_q [5];
    logic [CNT_W-1:0] cnt_d [5];
    logic [4:0]       btn_db_q;
    logic [4:0]       btn_db_d;
    logic [4:0]       btn_prev_q;
    logic [4:0]       pulse_s;

    ioreg_union_t     ioreg_q;
    ioreg_union_t     ioreg_d;
    test_selector_t   sel_q;
    test_selector_t   sel_d;
    logic             op_start_q;
    logic             op_start_d;

    // Synchronizer chain for every raw button and switch bit
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                sync_q[s] <= 21'd0;
            end
        end else begin
            sync_q[0] <= {btn_in, sw_in};
            for (int s = 1; s < SYNC_STAGES; s++) begin
                sync_q[s] <= sync_q[s-1];
            end
        end
    end

    assign btn_sync_s = sync_q[SYNC_STAGES-1][20:16];
    assign sw_sync_s  = sync_q[SYNC_STAGES-1][15:0];

    // Press detection from registered levels only
    assign pulse_s = btn_db_q & ~btn_prev_q;

    // Per-button debounce: count while the synced level differs, accept at the limit
    always_comb begin
        btn_db_d = btn_db_q;
        for (int i = 0; i < 5; i++) begin
            cnt_d[i] = cnt_q[i];
        end
        for (int i = 0; i < 5; i++) begin
            if (btn_sync_s[i] == btn_db_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CNT_MAX) begin
                cnt_d[i]    = '0;
                btn_db_d[i] = btn_sync_s[i];
            end else begin
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
        end
    end

    // Pulse-driven updates of operand register, test selector and execute request
    always_comb begin
        ioreg_d    = ioreg_q;
        sel_d      = sel_q;
        op_start_d = pulse_s[BTNC_IDX];
        if (pulse_s[BTNL_IDX]) begin
            ioreg_d.bytes.lo_byte = sw_sync_s[7:0];
        end else begin
            ioreg_d.bytes.lo_byte = ioreg_q.bytes.lo_byte;
        end
        if (pulse_s[BTNR_IDX]) begin
            ioreg_d.bytes.hi_byte = sw_sync_s[15:8];
        end else begin
            ioreg_d.bytes.hi_byte = ioreg_q.bytes.hi_byte;
        end
        if (pulse_s[BTNU_IDX] && !pulse_s[BTND_IDX]) begin
            case (sel_q)
                LEADING_ONES: sel_d = NUM_ONES;
                NUM_ONES:     sel_d = ADD;
                ADD:          sel_d = SUB;
                SUB:          sel_d = MULT;
                MULT:         sel_d = LEADING_ONES;
                default:      sel_d = LEADING_ONES;
            endcase
        end else if (pulse_s[BTND_IDX] && !pulse_s[BTNU_IDX]) begin
            case (sel_q)
                LEADING_ONES: sel_d = MULT;
                NUM_ONES:     sel_d = LEADING_ONES;
                ADD:          sel_d = NUM_ONES;
                SUB:          sel_d = ADD;
                MULT:         sel_d = SUB;
                default:      sel_d = LEADING_ONES;
            endcase
        end else begin
            sel_d = sel_q;
        end
    end

    // State registers; reset overrides any pending pulse-driven update
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 5; i++) begin
                cnt_q[i] <= '0;
            end
            btn_db_q      <= 5'd0;
            btn_prev_q    <= 5'd0;
            ioreg_q.word  <= 16'h0000;
            sel_q         <= LEADING_ONES;
            op_start_q    <= 1'b0;
        end else begin
            for (int i = 0; i < 5; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            btn_db_q      <= btn_db_d;
            btn_prev_q    <= btn_db_q;
            ioreg_q       <= ioreg_d;
            sel_q         <= sel_d;
            op_start_q    <= op_start_d;
        end
    end

    assign btn_db    = btn_db_q;
    assign btn_pulse = pulse_s;
    assign ioreg     = ioreg_q;
    assign test_sel  = sel_q;
    assign op_start  = op_start_q;

endmodule

// File: tb/tb_input_capture.sv
// Directed bench for input_capture with a small reference model; expected
// register values are queued when a press is driven and compared when the
// press reaches the outputs.
module tb_input_capture;
    import definitions_pkg::*;

    logic           clk;
    logic           reset;
    logic [4:0]     btn_in;
    logic [15:0]    sw_in;
    logic [4:0]     btn_db;
    logic [4:0]     btn_pulse;
    ioreg_union_t   ioreg;
    test_selector_t test_sel;
    logic           op_start;

    int checks;
    int errors;

    // Reference model state
    logic [15:0]    m_ioreg;
    int             m_idx;
    test_selector_t sel_order [5];

    // Scoreboard queues
    logic [15:0]    exp_io_q  [$];
    test_selector_t exp_sel_q [$];
    logic           exp_op_q  [$];

    input_capture #(
        .DEBOUNCE_CYCLES (4),
        .SYNC_STAGES     (2)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .btn_in    (btn_in),
        .sw_in     (sw_in),
        .btn_db    (btn_db),
        .btn_pulse (btn_pulse),
        .ioreg     (ioreg),
        .test_sel  (test_sel),
        .op_start  (op_start)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Drive a press of all buttons in mask, check its timing and effect, then release
    task automatic do_press(input string tag, input logic [4:0] mask, input logic [15:0] sw);
        int k;
        int bad;
        logic [15:0] e_io;
        int e_idx;
        e_io  = m_ioreg;
        e_idx = m_idx;
        if (mask[BTNL_IDX]) e_io[7:0]  = sw[7:0];
        if (mask[BTNR_IDX]) e_io[15:8] = sw[15:8];
        if (mask[BTNU_IDX] && !mask[BTND_IDX]) e_idx = (m_idx == 4) ? 0 : m_idx + 1;
        else if (mask[BTND_IDX] && !mask[BTNU_IDX]) e_idx = (m_idx == 0) ? 4 : m_idx - 1;
        m_ioreg = e_io;
        m_idx   = e_idx;
        exp_io_q.push_back(e_io);
        exp_sel_q.push_back(sel_order[e_idx]);
        exp_op_q.push_back(mask[BTNC_IDX]);

        sw_in  = sw;
        btn_in = mask;
        k = 0;
        while ((btn_pulse & mask) == 5'd0 && k < 20) begin
            tick();
            k++;
        end
        chk({tag, " latency"}, k, 6);
        chk({tag, " pulse"}, btn_pulse, mask);
        chk({tag, " btn_db"}, btn_db, mask);
        tick();
        chk({tag, " ioreg"}, ioreg.word, exp_io_q.pop_front());
        chk({tag, " test_sel"}, test_sel, exp_sel_q.pop_front());
        chk({tag, " op_start"}, op_start, exp_op_q.pop_front());
        bad = 0;
        repeat (5) begin
            tick();
            if (op_start !== 1'b0 || btn_pulse !== 5'd0) bad++;
        end
        chk({tag, " held quiet"}, bad, 0);
        btn_in = 5'd0;
        bad = 0;
        repeat (8) begin
            tick();
            if (op_start !== 1'b0 || btn_pulse !== 5'd0) bad++;
        end
        chk({tag, " release quiet"}, bad, 0);
        chk({tag, " released db"}, btn_db, 5'd0);
    endtask

    initial begin
        int k;
        int bad;
        int ops;
        checks = 0;
        errors = 0;
        sel_order[0] = LEADING_ONES;
        sel_order[1] = NUM_ONES;
        sel_order[2] = ADD;
        sel_order[3] = SUB;
        sel_order[4] = MULT;
        m_ioreg = 16'h0000;
        m_idx   = 0;

        // Reset state
        reset  = 1'b1;
        btn_in = 5'd0;
        sw_in  = 16'h0000;
        repeat (3) tick();
        reset = 1'b0;
        tick();
        chk("rst btn_db", btn_db, 5'd0);
        chk("rst btn_pulse", btn_pulse, 5'd0);
        chk("rst ioreg", ioreg.word, 16'h0000);
        chk("rst test_sel", test_sel, LEADING_ONES);
        chk("rst op_start", op_start, 1'b0);

        // BTNL loads the low byte only
        do_press("btnl", BTNL_MASK, 16'hA55A);

        // Short BTNU glitch is rejected
        btn_in = BTNU_MASK;
        repeat (3) tick();
        btn_in = 5'd0;
        bad = 0;
        repeat (10) begin
            tick();
            if (btn_db !== 5'd0 || btn_pulse !== 5'd0) bad++;
        end
        chk("glitch quiet", bad, 0);
        chk("glitch test_sel", test_sel, LEADING_ONES);

        // Five BTNU presses wrap around, then BTND steps back
        repeat (5) do_press("btnu", BTNU_MASK, 16'h0000);
        do_press("btnd", BTND_MASK, 16'h0000);

        // BTNR with BTNC: high byte and execute request on the same edge
        do_press("btnr+btnc", BTNR_MASK | BTNC_MASK, 16'h1234);

        // BTNU and BTND together cancel
        do_press("btnu+btnd", BTNU_MASK | BTND_MASK, 16'h0000);

        // BTNL and BTNR together load both bytes
        do_press("btnl+btnr", BTNL_MASK | BTNR_MASK, 16'hBEEF);

        // Reset in the middle of a BTNC debounce
        btn_in = BTNC_MASK;
        repeat (4) tick();
        reset = 1'b1;
        tick();
        chk("midrst btn_db", btn_db, 5'd0);
        chk("midrst ioreg", ioreg.word, 16'h0000);
        chk("midrst test_sel", test_sel, LEADING_ONES);
        chk("midrst op_start", op_start, 1'b0);
        reset   = 1'b0;
        m_ioreg = 16'h0000;
        m_idx   = 0;
        k = 0;
        while (btn_db[BTNC_IDX] !== 1'b1 && k < 20) begin
            tick();
            k++;
        end
        chk("midrst latency", k, 6);
        ops = 0;
        repeat (10) begin
            tick();
            if (op_start === 1'b1) ops++;
        end
        chk("midrst op_start count", ops, 1);
        btn_in = 5'd0;
        repeat (8) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/input_capture.md
INPUT_CAPTURE -- requirements
Module: input_capture

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 1_000_000, meaning consecutive stable cycles required to accept a button change (10 ms at 100 MHz); legal range 2..2^24.
REQ-002 SHALL have parameter SYNC_STAGES, default 2, meaning number of synchronizer flops on each button and switch input.
REQ-003 SHALL use one clock and a reset that is synchronous and active-high; port clk  input  1  system clock, all state on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous active-high reset.
REQ-005 SHALL have port btn_in  input  5  raw buttons {BTNC,BTNU,BTND,BTNL,BTNR}, bit4 = BTNC, matching the package button masks.
REQ-006 SHALL have port sw_in  input  16  raw slide switches.
REQ-007 SHALL have port btn_db  output  5  debounced button levels.
REQ-008 SHALL have port btn_pulse  output  5  one-cycle rising-edge pulse per debounced button.
REQ-009 SHALL have port ioreg  output  16  operand register, type ioreg_union_t from definitions_pkg.
REQ-010 SHALL have port test_sel  output  test_selector_t  currently selected test.
REQ-011 SHALL have port op_start  output  1  one-cycle request for the downstream test/ALU stage to execute.

Function
REQ-012 SHALL pass each btn_in and sw_in bit through SYNC_STAGES flops before any use; switches are not debounced.
REQ-013 SHALL keep one counter per button: cleared when synced level equals btn_db bit, incremented when different.
REQ-014 SHALL, when the counter equals DEBOUNCE_CYCLES-1 and synced level still differs, copy synced level into btn_db and clear the counter in the same edge.
REQ-015 SHALL ignore glitches: any return to the btn_db level before the count completes clears the counter with no btn_db change.
REQ-016 SHALL make btn_db change exactly SYNC_STAGES+DEBOUNCE_CYCLES rising edges after the first edge sampling a stable new raw level.
REQ-017 SHALL assert btn_pulse[i] combinationally from registers when btn_db[i]=1 and its previous-cycle value was 0; high exactly one cycle per press; no pulse on release.
REQ-018 SHALL on BTNL pulse load ioreg.lo_byte from synced sw_in[7:0] at the next edge; hi_byte unchanged.
REQ-019 SHALL on BTNR pulse load ioreg.hi_byte from synced sw_in[15:8] at the next edge; lo_byte unchanged.
REQ-020 SHALL on simultaneous BTNL and BTNR pulses load both bytes in the same edge.
REQ-021 SHALL on BTNU pulse advance test_sel LEADING_ONES->NUM_ONES->ADD->SUB->MULT->LEADING_ONES (wrap).
REQ-022 SHALL on BTND pulse step test_sel in reverse order, LEADING_ONES wrapping to MULT.
REQ-023 SHALL leave test_sel unchanged when BTNU and BTND pulse in the same cycle.
REQ-024 SHALL on BTNC pulse assert op_start for exactly one cycle beginning at the next edge.
REQ-025 SHALL, when BTNC pulses together with BTNL/BTNR/BTNU/BTND, apply register updates in the same edge op_start rises, so downstream sees new ioreg and test_sel with op_start.
REQ-026 SHALL never assert op_start in two consecutive cycles.

Reset
REQ-027 SHALL on reset clear all synchronizer flops, debounce counters, btn_db, previous-level registers, ioreg (16'h0000) and op_start; btn_pulse therefore 0.
REQ-028 SHALL on reset set test_sel to LEADING_ONES.
REQ-029 SHALL, when reset occurs mid-debounce, discard the partial count; a button held through reset release is re-debounced from zero and yields one btn_pulse.
REQ-030 SHALL give reset priority over every pulse-driven update in the same cycle.

Verification (DEBOUNCE_CYCLES=4, SYNC_STAGES=2)
REQ-031 SHALL check: reset, then BTNL raw high stable, sw_in=16'hA55A -> btn_db[1] rises 6 edges later, single btn_pulse[1], ioreg=16'h005A next edge.
REQ-032 SHALL check: BTNU raw high for 3 cycles then low -> no btn_db change, no pulse, test_sel stays LEADING_ONES.
REQ-033 SHALL check: five debounced BTNU presses -> test_sel sequence NUM_ONES, ADD, SUB, MULT, LEADING_ONES; then one BTND -> MULT.
REQ-034 SHALL check: BTNR and BTNC raw rise same cycle, sw_in=16'h1234 -> hi_byte=8'h12 and op_start high one cycle at same edge; held button produces no further op_start.
REQ-035 SHALL check: BTNU and BTND pressed simultaneously -> both pulses, test_sel unchanged.
REQ-036 SHALL check: reset asserted at count 2 with BTNC held -> outputs cleared; after release btn_db[4] rises 6 edges later and op_start pulses once.
